data_sync_arb: RTL and testbench

DATA_SYNC_ARB -- requirements
Module: data_sync_arb

---
 rtl/data_sync_arb.sv | 166 ++++++++++++++++
 tb/tb_data_sync_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sync_arb.sv
// data_sync_arb: per-channel enable synchronisers with rising-edge pulses,
// one-deep hold register per channel, and a round-robin arbiter that feeds
// a single ready/valid output register.
// Optional build macro: DATA_SYNC_ARB_OVF_STICKY_EN makes o_overflow sticky
// until reset; without it o_overflow is a one-cycle indication.
module data_sync_arb #(
  parameter  int NUM_STAGES = 2,
  parameter  int BUS_WIDTH  = 8,
  parameter  int NUM_CH     = 4,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                        i_CLK,
  input  logic                        i_RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] i_unsync_bus,
  input  logic [NUM_CH-1:0]           i_bus_enable,
  output logic [NUM_CH-1:0]           o_enable_pulse,
  output logic [BUS_WIDTH-1:0]        o_sync_bus,
  output logic [CH_W-1:0]             o_ch_id,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [NUM_CH-1:0]           o_overflow
);

  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    pend_vec;
  logic [NUM_CH-1:0]    pulse_vec;
  logic [NUM_CH-1:0]    ovf_vec;
  logic [BUS_WIDTH-1:0] hold_arr [NUM_CH];
  logic [BUS_WIDTH-1:0] bus_arr  [NUM_CH];

  logic                 grant_found;
  logic [CH_W-1:0]      grant_idx;
  logic                 load;

  logic                 valid_q, valid_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]      id_q, id_d;
  logic [CH_W-1:0]      last_q, last_d;

  // A word may enter the output register when it is empty or being drained.
  assign load = grant_found && (!valid_q || i_ready);

  genvar n;
  generate
    for (n = 0; n < NUM_CH; n++) begin : g_ch
      logic [NUM_STAGES-1:0] sync_q, sync_d;
      logic                  edge_q;
      logic                  pulse_q, pulse_d;
      logic                  pending_q, pending_d;
      logic [BUS_WIDTH-1:0]  hold_q, hold_d;
      logic                  ovf_q, ovf_d;
      logic                  drop;
      logic                  gnt;
      logic [BUS_WIDTH-1:0]  bus;

      assign bus = i_unsync_bus[n*BUS_WIDTH +: BUS_WIDTH];
      assign gnt = load && (grant_idx == CH_W'(n));

      // Synchroniser shift, edge detect and one-deep mailbox update.
      always_comb begin
        sync_d    = {sync_q[NUM_STAGES-2:0], i_bus_enable[n]};
        pulse_d   = sync_q[NUM_STAGES-1] & ~edge_q;
        pending_d = pending_q;
        hold_d    = hold_q;
        drop      = 1'b0;
        if (pulse_q) begin
          // A granted channel with no pending word takes the bus straight
          // to the output, so nothing is stored in that case.
          if (!gnt && pending_q) begin
            drop = 1'b1;
          end else if (!gnt || pending_q) begin
            hold_d    = bus;
            pending_d = 1'b1;
          end
        end else if (gnt) begin
          pending_d = 1'b0;
        end
`ifdef DATA_SYNC_ARB_OVF_STICKY_EN
        ovf_d = ovf_q | drop;
`else
        ovf_d = drop;
`endif
      end

      // Per-channel state registers with synchronous active-low reset.
      always_ff @(posedge i_CLK) begin
        if (!i_RST) begin
          sync_q    <= '0;
          edge_q    <= 1'b0;
          pulse_q   <= 1'b0;
          pending_q <= 1'b0;
          hold_q    <= '0;
          ovf_q     <= 1'b0;
        end else begin
          sync_q    <= sync_d;
          edge_q    <= sync_q[NUM_STAGES-1];
          pulse_q   <= pulse_d;
          pending_q <= pending_d;
          hold_q    <= hold_d;
          ovf_q     <= ovf_d;
        end
      end

      assign req[n]       = pending_q | pulse_q;
      assign pend_vec[n]  = pending_q;
      assign pulse_vec[n] = pulse_q;
      assign ovf_vec[n]   = ovf_q;
      assign hold_arr[n]  = hold_q;
      assign bus_arr[n]   = bus;
    end
  endgenerate

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && req[idx[CH_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx[CH_W-1:0];
      end
    end
  end

  // Output register next state: load a granted word or drain when accepted.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = pend_vec[grant_idx] ? hold_arr[grant_idx] : bus_arr[grant_idx];
      id_d    = grant_idx;
      last_d  = grant_idx;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Output and arbiter-pointer registers; pointer resets so channel 0 wins first.
  always_ff @(posedge i_CLK) begin
    if (!i_RST) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= CH_W'(NUM_CH - 1);
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  assign o_enable_pulse = pulse_vec;
  assign o_overflow     = ovf_vec;
  assign o_sync_bus     = data_q;
  assign o_ch_id        = id_q;
  assign o_valid        = valid_q;

endmodule

// File: tb/tb_data_sync_arb.sv
// Self-checking bench for data_sync_arb (NUM_STAGES=3, BUS_WIDTH=4, NUM_CH=4).
// A word-level reference model predicts every output each cycle; directed
// scenarios add explicit checks against fixed expected values.
module tb_data_sync_arb;
  localparam int NS  = 3;
  localparam int BW  = 4;
  localparam int NCH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH*BW-1:0] bus;
  logic [NCH-1:0]    en;
  logic              ready;
  logic [NCH-1:0]    pulse;
  logic [BW-1:0]     sync_bus;
  logic [1:0]        ch_id;
  logic              valid;
  logic [NCH-1:0]    ovf;

  always #5 clk = ~clk;

  data_sync_arb #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .NUM_CH(NCH)) dut (
    .i_CLK(clk), .i_RST(rst), .i_unsync_bus(bus), .i_bus_enable(en),
    .o_enable_pulse(pulse), .o_sync_bus(sync_bus), .o_ch_id(ch_id),
    .o_valid(valid), .i_ready(ready), .o_overflow(ovf)
  );

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;

  // reference model state
  bit [NCH-1:0] hist[$];
  bit [NCH-1:0] m_pulse, m_pend, m_ovf;
  bit [BW-1:0]  m_hold [NCH];
  bit           m_valid;
  bit [BW-1:0]  m_data;
  int           m_id, m_last;

  // observation logs
  int acc_id[$];
  int acc_data[$];
  int acc_cyc[$];
  int pulse_cnt [NCH];
  bit ovf_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] bus_of(input int c);
    return bus[c*BW +: BW];
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (NS + 2) hist.push_back('0);
    m_pulse = '0; m_pend = '0; m_ovf = '0;
    for (int c = 0; c < NCH; c++) m_hold[c] = '0;
    m_valid = 1'b0; m_data = '0; m_id = 0; m_last = NCH - 1;
  endtask

  // Predict the state after the coming edge from the current inputs.
  task automatic model_edge();
    bit [NCH-1:0] req, n_pend, drop, n_pulse;
    bit [BW-1:0]  n_hold [NCH];
    int g, c, L;
    bit n_valid;
    bit [BW-1:0] n_data;
    int n_id, n_last;
    if (!rst) begin
      model_reset();
      return;
    end
    req = m_pend | m_pulse;
    g = -1;
    if (!m_valid || ready) begin
      for (int k = 1; k <= NCH; k++) begin
        c = (m_last + k) % NCH;
        if (g < 0 && req[c]) g = c;
      end
    end
    n_valid = m_valid; n_data = m_data; n_id = m_id; n_last = m_last;
    n_pend = m_pend; n_hold = m_hold; drop = '0;
    if (g >= 0) begin
      n_valid = 1'b1;
      n_data  = m_pend[g] ? m_hold[g] : bus_of(g);
      n_id    = g;
      n_last  = g;
    end else if (m_valid && ready) begin
      n_valid = 1'b0;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      if (m_pulse[ch]) begin
        if (ch != g && m_pend[ch]) drop[ch] = 1'b1;
        else if (ch != g || m_pend[ch]) begin
          n_hold[ch] = bus_of(ch);
          n_pend[ch] = 1'b1;
        end
      end else if (ch == g) begin
        n_pend[ch] = 1'b0;
      end
    end
    hist.push_back(en);
    L = hist.size() - 1;
    n_pulse = hist[L-NS] & ~hist[L-NS-1];
    void'(hist.pop_front());
`ifdef DATA_SYNC_ARB_OVF_STICKY_EN
    m_ovf = m_ovf | drop;
`else
    m_ovf = drop;
`endif
    m_pulse = n_pulse; m_pend = n_pend; m_hold = n_hold;
    m_valid = n_valid; m_data = n_data; m_id = n_id; m_last = n_last;
  endtask

  task automatic tick();
    if (rst && valid && ready) begin
      acc_id.push_back(int'(ch_id));
      acc_data.push_back(int'(sync_bus));
      acc_cyc.push_back(cyc);
    end
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("pulse", pulse, m_pulse);
    chk("valid", valid, m_valid);
    chk("data",  sync_bus, m_data);
    chk("id",    ch_id, m_id);
    chk("ovf",   ovf, m_ovf);
    for (int c = 0; c < NCH; c++) if (pulse[c]) pulse_cnt[c]++;
    if (ovf != '0) ovf_seen = 1'b1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_bus(input int c, input int v);
    bus[c*BW +: BW] = v[BW-1:0];
  endtask

  task automatic clear_logs();
    acc_id.delete(); acc_data.delete(); acc_cyc.delete();
    for (int c = 0; c < NCH; c++) pulse_cnt[c] = 0;
    ovf_seen = 1'b0;
  endtask

  int exp_id [5];
  int exp_dat [5];
  int ch0_words;

  initial begin
    exp_id  = '{1, 2, 3, 0, 1};
    exp_dat = '{5, 10, 12, 6, 9};
    model_reset();
    clear_logs();

    // Reset held with all enables high, then one pulse per channel.
    rst = 1'b0; en = '1; ready = 1'b1; bus = 16'h4321;
    ticks(2);
    chk("rst_valid", valid, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", sync_bus, 0);
    rst = 1'b1;
    clear_logs();
    ticks(3);
    chk("rel_no_early_pulse", pulse, 0);
    tick();
    chk("rel_pulse_all", pulse, 4'hF);
    ticks(12);
    for (int c = 0; c < NCH; c++) chk("rel_pulse_cnt", pulse_cnt[c], 1);
    chk("rel_words", acc_id.size(), 4);
    en = '0;
    ticks(6);

    // Single channel-0 word: latency of pulse and output.
    set_bus(0, 11);
    en[0] = 1'b1;
    ticks(3);
    chk("lat_pulse_e3", pulse[0], 0);
    tick();
    chk("lat_pulse_e4", pulse[0], 1);
    tick();
    chk("lat_pulse_e5", pulse[0], 0);
    chk("lat_valid_e5", valid, 1);
    chk("lat_data_e5", sync_bus, 4'hB);
    chk("lat_id_e5", ch_id, 0);
    tick();
    chk("lat_valid_e6", valid, 0);
    en[0] = 1'b0;
    ticks(6);

    // Three simultaneous words, then ch0 beats ch1 after the pointer wraps.
    clear_logs();
    set_bus(1, 5); set_bus(2, 10); set_bus(3, 12);
    en[3:1] = 3'b111;
    ticks(10);
    en = '0;
    ticks(6);
    set_bus(0, 6); set_bus(1, 9);
    en[1:0] = 2'b11;
    ticks(10);
    en = '0;
    ticks(6);
    chk("rr_count", acc_id.size(), 5);
    if (acc_id.size() >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("rr_id", acc_id[i], exp_id[i]);
        chk("rr_data", acc_data[i], exp_dat[i]);
      end
      chk("rr_consec1", acc_cyc[1] - acc_cyc[0], 1);
      chk("rr_consec2", acc_cyc[2] - acc_cyc[1], 1);
    end

    // Overflow: output blocked by ch1, ch0 holds 3, then a second word 7.
    clear_logs();
    ready = 1'b0;
    set_bus(1, 1);
    en[1] = 1'b1;
    ticks(6);
    chk("ovf_out_busy", valid, 1);
    en[1] = 1'b0;
    set_bus(0, 3);
    en[0] = 1'b1;
    ticks(6);
    en[0] = 1'b0;
    ticks(5);
    set_bus(0, 7);
    en[0] = 1'b1;
    ticks(6);
    chk("ovf_seen", ovf_seen, 1);
    en[0] = 1'b0;
    ready = 1'b1;
    ticks(10);
    ch0_words = 0;
    for (int i = 0; i < acc_id.size(); i++) begin
      if (acc_id[i] == 0) begin
        ch0_words++;
        chk("ovf_ch0_data", acc_data[i], 3);
      end
    end
    chk("ovf_ch0_words", ch0_words, 1);

    // Reset mid-transfer with one word out and two pending.
    ready = 1'b0;
    set_bus(1, 4); set_bus(2, 5); set_bus(3, 6);
    en[3:1] = 3'b111;
    ticks(6);
    chk("mid_valid_before", valid, 1);
    rst = 1'b0;
    en = '0;
    tick();
    chk("mid_valid_rst", valid, 0);
    chk("mid_ovf_rst", ovf, 0);
    rst = 1'b1;
    ready = 1'b1;
    clear_logs();
    ticks(12);
    chk("mid_no_stale", acc_id.size(), 0);

    // Enable held high for 20 cycles gives one pulse and one word.
    clear_logs();
    set_bus(2, 13);
    en[2] = 1'b1;
    ticks(20);
    chk("hold_pulses", pulse_cnt[2], 1);
    chk("hold_words", acc_id.size(), 1);
    if (acc_id.size() >= 1) chk("hold_data", acc_data[0], 13);
    en = '0;
    ticks(6);

    // Randomised traffic against the reference model.
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (en[c]) begin
          if ($urandom_range(0, 3) == 0) en[c] = 1'b0;
        end else if ($urandom_range(0, 5) == 0) begin
          en[c] = 1'b1;
        end else if ($urandom_range(0, 1) == 0) begin
          set_bus(c, int'($urandom_range(0, 15)));
        end
      end
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 149) != 0);
      tick();
    end
    rst = 1'b1;
    en = '0;
    ticks(8);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
